uart_rx_sampler: RTL and testbench

Oversampling UART receive front end. It turns the raw `rx` pin into framed bytes plus one-cycle `done`/`err` strobes for the Rx FIFO write logic in the AHB UART wrapper; the wrapper writes the FIFO on `done && !err`. Timing comes from an external oversample enable (`tick`) driven by the baud rate generator at OVERSAMPLE × baud. The block adds input synchronisation, 3-sample majority voting, false-start rejection and optional parity.

---
 rtl/uart_rx_sampler.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front end: synchronises rx, majority-votes three
// samples around mid-bit, rejects false starts and checks optional parity.
module uart_rx_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       syncReset,
    input  logic       tick,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] data,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] M_LO    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] M_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] M_HI    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   sync_in;
    logic                   rxs;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          xor_q, xor_d;
    logic          pen_q, pen_d;
    logic          podd_q, podd_d;
    logic          pbad_q, pbad_d;
    logic          s_lo_q, s_lo_d;
    logic          s_mid_q, s_mid_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          vote;

    // The synchroniser runs every clk; only the frame logic is gated by tick.
    assign sync_in = {sync_q, rx};
    assign rxs     = sync_in[SYNC_STAGES];

    assign vote = (s_lo_q & s_mid_q) | (s_lo_q & rxs) | (s_mid_q & rxs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        xor_d   = xor_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        pbad_d  = pbad_q;
        s_lo_d  = s_lo_q;
        s_mid_d = s_mid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (tick) begin
            if (state_q != IDLE) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == M_LO) begin
                    s_lo_d = rxs;
                end
                if (cnt_q == M_MID) begin
                    s_mid_d = rxs;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = CW'(1);
                        bit_d   = '0;
                        shift_d = '0;
                        xor_d   = 1'b0;
                        pbad_d  = 1'b0;
                        pen_d   = parity_en;
                        podd_d  = parity_odd;
                    end
                end
                START: begin
                    if (cnt_q == M_HI && vote) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == M_HI) begin
                        shift_d[bit_q] = vote;
                        xor_d          = xor_q ^ vote;
                    end
                    if (cnt_q == CNT_MAX) begin
                        if (bit_q == LAST) begin
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == M_HI) begin
                        pbad_d = (xor_q ^ vote) != podd_q;
                    end
                    if (cnt_q == CNT_MAX) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Decide at mid stop bit so a short stop bit still resyncs.
                    if (cnt_q == M_HI) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        err_d   = ~vote | pbad_q;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (syncReset) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            xor_q   <= 1'b0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            pbad_q  <= 1'b0;
            s_lo_q  <= 1'b1;
            s_mid_q <= 1'b1;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_in[SYNC_STAGES-1:0];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            xor_q   <= xor_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            pbad_q  <= pbad_d;
            s_lo_q  <= s_lo_d;
            s_mid_q <= s_mid_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed plus randomized frames against a bit-slot level model of the receiver.
module tb_uart_rx_sampler;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int M  = OS / 2;

    logic       clk = 1'b0;
    logic       syncReset;
    logic       tick;
    logic       rx;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] data;
    logic       done;
    logic       err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .syncReset  (syncReset),
        .tick       (tick),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .data       (data),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    int         done_cnt    = 0;
    int         busy_ticks  = 0;
    int         strobe_viol = 0;
    logic       prev_done   = 1'b0;
    logic [7:0] got_data[$];
    logic       got_err[$];

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            got_data.push_back(data);
            got_err.push_back(err);
        end
        if (err && !done) strobe_viol++;
        if (done && prev_done) strobe_viol++;
        prev_done = done;
        if (tick && busy) busy_ticks++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // fast=1: tick every clk; fast=0: rx settles through the synchroniser before each tick.
    bit   fast;
    logic fq[$];

    task automatic slot(input logic v);
        rx = v;
        if (fast) begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
        end else begin
            tick = 1'b0;
            repeat (2 + $urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) slot(1'b1);
    endtask

    task automatic build(input logic [7:0] b, input logic with_par, input logic pbit,
                         input logic stopv, input int stoplen);
        repeat (OS) fq.push_back(1'b0);
        for (int i = 0; i < DB; i++) repeat (OS) fq.push_back(b[i]);
        if (with_par) repeat (OS) fq.push_back(pbit);
        repeat (stoplen) fq.push_back(stopv);
    endtask

    task automatic play(input int n, input logic pen_mid, input logic podd_mid);
        for (int i = 0; i < n && i < fq.size(); i++) begin
            slot(fq[i]);
            if (i == 4) begin
                parity_en  = pen_mid;
                parity_odd = podd_mid;
            end
        end
    endtask

    task automatic pop_frame(output logic [31:0] od, output logic [31:0] oe);
        if (got_data.size() > 0) begin
            od = 32'(got_data.pop_front());
            oe = 32'(got_err.pop_front());
        end else begin
            od = 'x;
            oe = 'x;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic pen,
                             input logic podd, input logic pbit, input logic stopv,
                             input int glitch);
        int          d0;
        int          stoplen;
        logic        exp_err;
        logic [31:0] od, oe;
        stoplen    = stopv ? $urandom_range(10, 16) : 16;
        parity_en  = pen;
        parity_odd = podd;
        fq.delete();
        build(b, pen, pbit, stopv, stoplen);
        if (glitch >= 0) fq[glitch] = 1'b0;
        d0 = done_cnt;
        play(fq.size(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(20);
        exp_err = !stopv || (pen && ((($countones(b) + int'(pbit)) % 2) != int'(podd)));
        check({tag, "/done"}, 32'(done_cnt - d0), 32'd1);
        pop_frame(od, oe);
        check({tag, "/data"}, od, 32'(b));
        check({tag, "/err"}, oe, 32'(exp_err));
        check({tag, "/idle"}, 32'(busy), 32'd0);
        got_data.delete();
        got_err.delete();
        $display("[TB] %s byte=%02h par=%0d/%0d/%0d stop=%0d fast=%0d -> data=%02h err=%0h",
                 tag, b, pen, podd, pbit, stopv, fast, od[7:0], oe);
    endtask

    initial begin
        int          d0;
        int          bt0;
        logic [31:0] od, oe;

        syncReset  = 1'b1;
        tick       = 1'b0;
        rx         = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        fast       = 1'b0;
        repeat (3) @(posedge clk);
        #1 syncReset = 1'b0;
        check("rst/data", 32'(data), 32'h0);
        check("rst/done", 32'(done), 32'h0);
        check("rst/err",  32'(err),  32'h0);
        check("rst/busy", 32'(busy), 32'h0);
        idle(4);

        // Clean 0x55, busy measured in ticks: start tick through stop vote tick.
        bt0 = busy_ticks;
        run_frame("t1_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        check("t1_busy_ticks", 32'(busy_ticks - bt0), 32'(OS * (1 + DB) + M + 1));

        // False start: three low ticks then high.
        d0 = done_cnt;
        repeat (3) slot(1'b0);
        check("t2_busy_rise", 32'(busy), 32'd1);
        repeat (6) slot(1'b1);
        check("t2_busy_hold", 32'(busy), 32'd1);
        slot(1'b1);
        check("t2_busy_fall", 32'(busy), 32'd0);
        idle(10);
        check("t2_no_done", 32'(done_cnt - d0), 32'd0);
        $display("[TB] t2_false_start dones=%0d busy=%0d", done_cnt - d0, busy);

        run_frame("t3_stoplow", 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_frame("t4_par_ok",  8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        run_frame("t4_par_bad", 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_frame("t5_glitch",  8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, OS + M);

        // Reset in the middle of bit 4 abandons the frame silently.
        parity_en = 1'b0;
        fq.delete();
        build(8'hA5, 1'b0, 1'b0, 1'b1, 16);
        d0 = done_cnt;
        play(OS * 5 + M, 1'b0, 1'b0);
        syncReset = 1'b1;
        @(posedge clk); #1;
        syncReset = 1'b0;
        rx = 1'b1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        idle(20);
        check("t6_no_strobe", 32'(done_cnt - d0), 32'd0);
        $display("[TB] t6_midframe_reset dones=%0d busy=%0d", done_cnt - d0, busy);
        run_frame("t6_3C", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1);

        // Back-to-back frames with a short stop bit.
        parity_en = 1'b0;
        fq.delete();
        build(8'h12, 1'b0, 1'b0, 1'b1, 10);
        build(8'h34, 1'b0, 1'b0, 1'b1, 16);
        d0 = done_cnt;
        play(fq.size(), 1'b0, 1'b0);
        idle(20);
        check("t6_b2b_count", 32'(done_cnt - d0), 32'd2);
        pop_frame(od, oe);
        check("t6_b2b_data0", od, 32'h12);
        check("t6_b2b_err0",  oe, 32'h0);
        $display("[TB] t6_b2b first data=%02h err=%0h", od[7:0], oe);
        pop_frame(od, oe);
        check("t6_b2b_data1", od, 32'h34);
        check("t6_b2b_err1",  oe, 32'h0);
        $display("[TB] t6_b2b second data=%02h err=%0h", od[7:0], oe);
        got_data.delete();
        got_err.delete();

        // Randomized frames, mixing continuous and gapped tick.
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            logic       pen, podd, pbit, stopv;
            b     = 8'($urandom);
            pen   = 1'($urandom_range(0, 1));
            podd  = 1'($urandom_range(0, 1));
            pbit  = 1'($urandom_range(0, 1));
            stopv = ($urandom_range(0, 3) != 0);
            fast  = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", n), b, pen, podd, pbit, stopv, -1);
        end

        check("strobe_shape", 32'(strobe_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
